// File: rtl/pwl_act_pkg.sv
// Shared types and Q-format constants for the piecewise-linear tanh/sigmoid block.
// Constants are derived from FRAC, so 1.0 is 2^FRAC.
package pwl_act_pkg;

   typedef enum logic {
      MODE_TANH = 1'b0,
      MODE_SIGM = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      SEG_LIN  = 2'd0,
      SEG_HALF = 2'd1,
      SEG_QTR  = 2'd2,
      SEG_SAT  = 2'd3
   } seg_e;

   // Upper breakpoint of a region in |x|; SEG_SAT extends to the top of the range.
   function automatic int seg_bound(input int frac, input seg_e seg);
      case (seg)
         SEG_LIN:  return 1 << (frac - 1);
         SEG_HALF: return 1 << frac;
         default:  return 1 << (frac + 1);
      endcase
   endfunction

   function automatic int seg_offset(input int frac, input seg_e seg);
      case (seg)
         SEG_LIN:  return 0;
         SEG_HALF: return 1 << (frac - 2);
         SEG_QTR:  return 1 << (frac - 1);
         default:  return 1 << frac;
      endcase
   endfunction

   // Sigmoid slope is a quarter of the tanh slope: d/dx (t(x/2)+1)/2 = t'/4.
   function automatic int seg_slope(input int frac, input mode_e mode, input seg_e seg);
      int s;
      case (seg)
         SEG_LIN:  s = 1 << frac;
         SEG_HALF: s = 1 << (frac - 1);
         SEG_QTR:  s = 1 << (frac - 2);
         default:  s = 0;
      endcase
      if (mode == MODE_SIGM) s = s >>> 2;
      return s;
   endfunction

endpackage

// File: rtl/pwl_seg_decode.sv
// Combinational magnitude and region classifier for the activation front end.
module pwl_seg_decode
   import pwl_act_pkg::*;
#(
   parameter int WIDTH = 24,
   parameter int FRAC  = 20
) (
   input  logic signed [WIDTH-1:0] operand,
   output seg_e                    seg
);

   localparam logic [WIDTH-1:0] BP_LIN  = WIDTH'(seg_bound(FRAC, SEG_LIN));
   localparam logic [WIDTH-1:0] BP_HALF = WIDTH'(seg_bound(FRAC, SEG_HALF));
   localparam logic [WIDTH-1:0] BP_QTR  = WIDTH'(seg_bound(FRAC, SEG_QTR));

   logic [WIDTH-1:0] mag;

   // Unsigned magnitude: the most negative operand maps to 2^(WIDTH-1), which
   // lands in SEG_SAT without a special case.
   always_comb begin
      mag = operand[WIDTH-1] ? $unsigned(-operand) : $unsigned(operand);
      if (mag < BP_LIN)
         seg = SEG_LIN;
      else if (mag < BP_HALF)
         seg = SEG_HALF;
      else if (mag < BP_QTR)
         seg = SEG_QTR;
      else
         seg = SEG_SAT;
   end

endmodule

// File: rtl/pwl_activation.sv
// Three-stage piecewise-linear tanh/sigmoid with a saturation counter.
// Define PWL_ACT_DERIV_EN to add o_deriv, the segment slope aligned with o_data.
module pwl_activation
   import pwl_act_pkg::*;
#(
   parameter int WIDTH = 24,
   parameter int FRAC  = 20,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [WIDTH-1:0] i_data,
   input  logic                    i_mode,
   input  logic                    i_valid,
   output logic                    i_ready,
   output logic                    o_valid,
   input  logic                    o_ready,
   output logic signed [WIDTH-1:0] o_data,
`ifdef PWL_ACT_DERIV_EN
   output logic signed [WIDTH-1:0] o_deriv,
`endif
   input  logic                    i_clr,
   output logic [CNT_W-1:0]        o_sat_cnt
);

   localparam logic signed [WIDTH-1:0] ONE      = WIDTH'(seg_offset(FRAC, SEG_SAT));
   localparam logic signed [WIDTH-1:0] OFF_HALF = WIDTH'(seg_offset(FRAC, SEG_HALF));
   localparam logic signed [WIDTH-1:0] OFF_QTR  = WIDTH'(seg_offset(FRAC, SEG_QTR));

   logic                    en;
   mode_e                   in_mode, s1_mode, s2_mode;
   seg_e                    in_seg, s1_seg;
   logic signed [WIDTH-1:0] operand, s1_x;
   logic signed [WIDTH-1:0] term, offset, s2_term, s2_off;
   logic signed [WIDTH-1:0] sum, result;
   logic                    s1_valid, s2_valid, s2_sat, s3_sat;
`ifdef PWL_ACT_DERIV_EN
   logic signed [WIDTH-1:0] s2_deriv;
`endif

   assign en      = ~o_valid | o_ready;
   assign i_ready = en;
   assign in_mode = mode_e'(i_mode);
   // Sigmoid reuses the tanh curve on x/2.
   assign operand = (in_mode == MODE_SIGM) ? (i_data >>> 1) : i_data;

   pwl_seg_decode #(.WIDTH(WIDTH), .FRAC(FRAC)) u_decode (
      .operand (operand),
      .seg     (in_seg)
   );

   always_comb begin
      term   = '0;
      offset = '0;
      case (s1_seg)
         SEG_LIN:  term = s1_x;
         SEG_HALF: begin term = s1_x >>> 1; offset = OFF_HALF; end
         SEG_QTR:  begin term = s1_x >>> 2; offset = OFF_QTR;  end
         default:  offset = ONE;
      endcase
      if (s1_x[WIDTH-1]) offset = -offset;
   end

   assign sum    = s2_term + s2_off;
   assign result = (s2_mode == MODE_SIGM) ? ((sum + ONE) >>> 1) : sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_mode  <= MODE_TANH;
         s1_seg   <= SEG_LIN;
         s2_valid <= 1'b0;
         s2_term  <= '0;
         s2_off   <= '0;
         s2_mode  <= MODE_TANH;
         s2_sat   <= 1'b0;
         o_valid  <= 1'b0;
         o_data   <= '0;
         s3_sat   <= 1'b0;
`ifdef PWL_ACT_DERIV_EN
         s2_deriv <= '0;
         o_deriv  <= '0;
`endif
      end else if (en) begin
         s1_valid <= i_valid;
         s1_x     <= operand;
         s1_mode  <= in_mode;
         s1_seg   <= in_seg;
         s2_valid <= s1_valid;
         s2_term  <= term;
         s2_off   <= offset;
         s2_mode  <= s1_mode;
         s2_sat   <= (s1_seg == SEG_SAT);
         o_valid  <= s2_valid;
         o_data   <= result;
         s3_sat   <= s2_sat;
`ifdef PWL_ACT_DERIV_EN
         s2_deriv <= WIDTH'(seg_slope(FRAC, s1_mode, s1_seg));
         o_deriv  <= s2_deriv;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         o_sat_cnt <= '0;
      else if (i_clr)
         o_sat_cnt <= '0;
      else if (o_valid && o_ready && s3_sat && !(&o_sat_cnt))
         o_sat_cnt <= o_sat_cnt + 1'b1;
   end

endmodule

// File: tb/tb_pwl_activation.sv
// Directed bench for pwl_activation at WIDTH=24, FRAC=20 with hand-computed vectors.
module tb_pwl_activation;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] i_data = '0;
   logic        i_mode = 1'b0;
   logic        i_valid = 1'b0;
   logic        i_ready;
   logic        o_valid;
   logic        o_ready = 1'b1;
   logic [23:0] o_data;
`ifdef PWL_ACT_DERIV_EN
   logic [23:0] o_deriv;
`endif
   logic        i_clr = 1'b0;
   logic [15:0] o_sat_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pwl_activation #(.WIDTH(24), .FRAC(20), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_data    (i_data),
      .i_mode    (i_mode),
      .i_valid   (i_valid),
      .i_ready   (i_ready),
      .o_valid   (o_valid),
      .o_ready   (o_ready),
      .o_data    (o_data),
`ifdef PWL_ACT_DERIV_EN
      .o_deriv   (o_deriv),
`endif
      .i_clr     (i_clr),
      .o_sat_cnt (o_sat_cnt)
   );

   typedef struct packed {
      logic [23:0] x;
      logic        m;
      logic [23:0] y;
      logic        s;
      logic [23:0] d;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One isolated beat: checks prior sat count, the 3-cycle latency and the result.
   task automatic run_one(input vec_t v, input string tag, input int exp_sat);
      @(negedge clk);
      check({tag, "_satcnt"}, 32'(o_sat_cnt), 32'(exp_sat));
      i_data = v.x; i_mode = v.m; i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      check({tag, "_lat1"}, 32'(o_valid), 32'd0);
      @(negedge clk);
      check({tag, "_lat2"}, 32'(o_valid), 32'd0);
      @(negedge clk);
      check({tag, "_valid"}, 32'(o_valid), 32'd1);
      check({tag, "_data"}, 32'(o_data), 32'(v.y));
`ifdef PWL_ACT_DERIV_EN
      check({tag, "_deriv"}, 32'(o_deriv), 32'(v.d));
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] sx [8];
      logic [23:0] sy [8];
      logic [23:0] held;
      int exp_sat, sent, got;

      //        x           mode  y           sat   deriv
      vecs = '{'{24'h0C0000, 1'b0, 24'h0A0000, 1'b0, 24'h080000},
               '{24'h180000, 1'b0, 24'h0E0000, 1'b0, 24'h040000},
               '{24'hD00000, 1'b0, 24'hF00000, 1'b1, 24'h000000},
               '{24'h040000, 1'b0, 24'h040000, 1'b0, 24'h100000},
               '{24'h07FFFF, 1'b0, 24'h07FFFF, 1'b0, 24'h100000},
               '{24'h080000, 1'b0, 24'h080000, 1'b0, 24'h080000},
               '{24'h100000, 1'b0, 24'h0C0000, 1'b0, 24'h040000},
               '{24'hF40000, 1'b0, 24'hF60000, 1'b0, 24'h080000},
               '{24'hE80000, 1'b0, 24'hF20000, 1'b0, 24'h040000},
               '{24'h200000, 1'b0, 24'h100000, 1'b1, 24'h000000},
               '{24'h800000, 1'b0, 24'hF00000, 1'b1, 24'h000000},
               '{24'h000000, 1'b1, 24'h080000, 1'b0, 24'h040000},
               '{24'h100000, 1'b1, 24'h0C0000, 1'b0, 24'h020000},
               '{24'h800000, 1'b1, 24'h000000, 1'b1, 24'h000000},
               '{24'hF00000, 1'b1, 24'h040000, 1'b0, 24'h020000},
               '{24'h500000, 1'b1, 24'h100000, 1'b1, 24'h000000},
               '{24'h300000, 1'b1, 24'h0F0000, 1'b0, 24'h010000}};

      sx = '{24'h010000, 24'h020000, 24'h030000, 24'h040000,
             24'h050000, 24'h060000, 24'h070000, 24'h0C0000};
      sy = '{24'h010000, 24'h020000, 24'h030000, 24'h040000,
             24'h050000, 24'h060000, 24'h070000, 24'h0A0000};

      // Reset state
      @(negedge clk);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_data", 32'(o_data), 32'd0);
      check("rst_satcnt", 32'(o_sat_cnt), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", 32'(i_ready), 32'd1);

      // Isolated beats, both modes and all region boundaries
      exp_sat = 0;
      for (int i = 0; i < 17; i++) begin
         run_one(vecs[i], $sformatf("v%0d", i), exp_sat);
         if (vecs[i].s) exp_sat++;
      end
      @(negedge clk);
      check("satcnt_total", 32'(o_sat_cnt), 32'(exp_sat));

      // Stream of 8 with a 4-cycle downstream stall
      sent = 0; got = 0; held = '0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         o_ready = !(c >= 5 && c < 9);
         i_mode  = 1'b0;
         i_valid = (sent < 8);
         i_data  = (sent < 8) ? sx[sent] : 24'h0;
         #1;
         if (o_valid && o_ready) begin
            if (got < 8) check($sformatf("stream%0d", got), 32'(o_data), 32'(sy[got]));
            got++;
         end else if (o_valid && !o_ready) begin
            if (c == 5) held = o_data;
            else check($sformatf("stall_hold%0d", c), 32'(o_data), 32'(held));
         end
         if (i_valid && i_ready) sent++;
      end
      i_valid = 1'b0;
      o_ready = 1'b1;
      check("stream_sent", 32'(sent), 32'd8);
      check("stream_got", 32'(got), 32'd8);

      // Clear coinciding with a saturated handshake
      @(negedge clk);
      check("pre_clr_satcnt", 32'(o_sat_cnt), 32'(exp_sat));
      i_data = 24'hD00000; i_mode = 1'b0; i_valid = 1'b1;
      @(negedge clk); i_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("clr_valid", 32'(o_valid), 32'd1);
      check("clr_data", 32'(o_data), 32'hF00000);
      i_clr = 1'b1;
      @(negedge clk);
      i_clr = 1'b0;
      check("clr_wins", 32'(o_sat_cnt), 32'd0);
      run_one(vecs[2], "after_clr", 0);
      @(negedge clk);
      check("after_clr_inc", 32'(o_sat_cnt), 32'd1);

      // Reset with 3 beats in flight
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         i_data = 24'h040000; i_mode = 1'b0; i_valid = 1'b1;
      end
      @(negedge clk);
      i_valid = 1'b0;
      check("inflight_valid", 32'(o_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(o_valid), 32'd0);
      check("async_rst_data", 32'(o_data), 32'd0);
      check("async_rst_satcnt", 32'(o_sat_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(i_ready), 32'd1);
      check("post_rst_valid", 32'(o_valid), 32'd0);
      repeat (3) @(negedge clk);
      check("discarded", 32'(o_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
